mips_multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control unit: the producer side of the ALU control interface.
//  - Sequences each instruction through a Moore FSM.
//  - Drives datapath enables, mux selects and aluControl_o into the ALU.
//  - Samples the ALU zero flag back for beq.
//  - Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
//  - Waits on a memory-ready handshake during memory states.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU control codes, ALU operation classes and the controller state set.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } ctrl_state_t;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decode: operation class plus funct field to the
// 3-bit ALU control code. Unknown functs fall back to ADD and are flagged.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       illegal_o
);

    // Map operation class (and funct for R-type) to an ALU control code.
    always_comb begin
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALU_ADD;
                    FN_SUB:  alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    default: illegal_o     = 1'b1;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit. A Moore FSM sequences each instruction and
// drives datapath enables, mux selects and the ALU control code. While reset
// is held every output is forced to its idle value, so an asynchronous reset
// cuts off a pending memory write in the same cycle.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       memReady_i,
    output logic       pcEn_o,
    output logic       iOrD_o,
    output logic       memWrite_o,
    output logic       irWrite_o,
    output logic       regDst_o,
    output logic       memToReg_o,
    output logic       regWrite_o,
    output logic       aluSrcA_o,
    output logic [1:0] aluSrcB_o,
    output logic [1:0] pcSrc_o,
    output logic [2:0] aluControl_o,
    output logic       illegal_o
);

    ctrl_state_t state_q, state_d;
    alu_op_t     alu_op;
    logic        mem_ready;
    logic        pc_write;
    logic        branch;
    logic        op_illegal;
    logic        funct_illegal;

    assign mem_ready = USE_MEM_READY ? memReady_i : 1'b1;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (funct_i),
        .alu_control_o (aluControl_o),
        .illegal_o     (funct_illegal)
    );

    assign pcEn_o    = pc_write | (branch & zero_i);
    assign illegal_o = op_illegal | funct_illegal;

    // State register; asynchronous reset returns to FETCH.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; any unknown encoding falls back to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode_i == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXECUTE: state_d = funct_illegal ? FETCH : ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode from the registered state, forced idle during reset.
    always_comb begin
        iOrD_o     = 1'b0;
        memWrite_o = 1'b0;
        irWrite_o  = 1'b0;
        regDst_o   = 1'b0;
        memToReg_o = 1'b0;
        regWrite_o = 1'b0;
        aluSrcA_o  = 1'b0;
        aluSrcB_o  = 2'b00;
        pcSrc_o    = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        op_illegal = 1'b0;
        case (state_q)
            FETCH: begin
                aluSrcB_o = 2'b01;
                irWrite_o = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                aluSrcB_o  = 2'b11;
                op_illegal = !is_supported_op(opcode_i);
            end
            MEMADR: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
            end
            MEMRD:   iOrD_o = 1'b1;
            MEMWB: begin
                memToReg_o = 1'b1;
                regWrite_o = 1'b1;
            end
            MEMWR: begin
                iOrD_o     = 1'b1;
                memWrite_o = 1'b1;
            end
            EXECUTE: begin
                aluSrcA_o = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                regDst_o   = 1'b1;
                regWrite_o = 1'b1;
            end
            BRANCH: begin
                aluSrcA_o = 1'b1;
                alu_op    = ALUOP_SUB;
                pcSrc_o   = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
            end
            ADDIWB:  regWrite_o = 1'b1;
            JUMP: begin
                pcSrc_o  = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n_i) begin
            iOrD_o     = 1'b0;
            memWrite_o = 1'b0;
            irWrite_o  = 1'b0;
            regDst_o   = 1'b0;
            memToReg_o = 1'b0;
            regWrite_o = 1'b0;
            aluSrcA_o  = 1'b0;
            aluSrcB_o  = 2'b00;
            pcSrc_o    = 2'b00;
            alu_op     = ALUOP_ADD;
            pc_write   = 1'b0;
            branch     = 1'b0;
            op_illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for the multicycle MIPS controller. The driver walks each
// instruction through its expected phase sequence, pushing the expected output
// vector for every cycle; the monitor pops and compares on each falling edge.
module tb_mips_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [5:0] opcode_i = 6'd0;
    logic [5:0] funct_i = 6'd0;
    logic       zero_i = 1'b0;
    logic       memReady_i = 1'b0;
    logic       pcEn_o, iOrD_o, memWrite_o, irWrite_o, regDst_o, memToReg_o;
    logic       regWrite_o, aluSrcA_o, illegal_o;
    logic [1:0] aluSrcB_o, pcSrc_o;
    logic [2:0] aluControl_o;

    mips_multicycle_ctrl dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .opcode_i     (opcode_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .memReady_i   (memReady_i),
        .pcEn_o       (pcEn_o),
        .iOrD_o       (iOrD_o),
        .memWrite_o   (memWrite_o),
        .irWrite_o    (irWrite_o),
        .regDst_o     (regDst_o),
        .memToReg_o   (memToReg_o),
        .regWrite_o   (regWrite_o),
        .aluSrcA_o    (aluSrcA_o),
        .aluSrcB_o    (aluSrcB_o),
        .pcSrc_o      (pcSrc_o),
        .aluControl_o (aluControl_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic [2:0] alu;
        logic       illegal;
    } outv_t;

    typedef struct {
        outv_t v;
        int    ph;
    } exp_t;

    // Phase identifiers, numbered in the order the behaviour table lists them.
    localparam int P_RST    = 0;
    localparam int P_FETCH  = 1;
    localparam int P_DECODE = 2;
    localparam int P_MEMADR = 3;
    localparam int P_MEMRD  = 4;
    localparam int P_MEMWB  = 5;
    localparam int P_MEMWR  = 6;
    localparam int P_EXEC   = 7;
    localparam int P_ALUWB  = 8;
    localparam int P_BRANCH = 9;
    localparam int P_ADDIEX = 10;
    localparam int P_ADDIWB = 11;
    localparam int P_JUMP   = 12;

    exp_t  q[$];
    int    total = 0;
    int    bad = 0;
    outv_t got;

    assign got = {pcEn_o, iOrD_o, memWrite_o, irWrite_o, regDst_o, memToReg_o,
                  regWrite_o, aluSrcA_o, aluSrcB_o, pcSrc_o, aluControl_o, illegal_o};

    // Returns {legal, alu code} for an R-type funct.
    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b101010: return {1'b1, 3'b111};
            default:   return {1'b0, 3'b010};
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    function automatic outv_t expect_out(input int ph, input logic rdy, input logic z,
                                         input logic [5:0] op, input logic [5:0] fn);
        outv_t      v;
        logic [3:0] fa;
        v     = '0;
        v.alu = 3'b010;
        fa    = funct_alu(fn);
        case (ph)
            P_FETCH:  begin v.src_b = 2'b01; v.ir_write = rdy; v.pc_en = rdy; end
            P_DECODE: begin v.src_b = 2'b11; v.illegal = !op_known(op); end
            P_MEMADR: begin v.src_a = 1'b1; v.src_b = 2'b10; end
            P_MEMRD:  v.i_or_d = 1'b1;
            P_MEMWB:  begin v.mem_to_reg = 1'b1; v.reg_write = 1'b1; end
            P_MEMWR:  begin v.i_or_d = 1'b1; v.mem_write = 1'b1; end
            P_EXEC:   begin v.src_a = 1'b1; v.alu = fa[2:0]; v.illegal = !fa[3]; end
            P_ALUWB:  begin v.reg_dst = 1'b1; v.reg_write = 1'b1; end
            P_BRANCH: begin v.src_a = 1'b1; v.alu = 3'b110; v.pc_src = 2'b01; v.pc_en = z; end
            P_ADDIEX: begin v.src_a = 1'b1; v.src_b = 2'b10; end
            P_ADDIWB: v.reg_write = 1'b1;
            P_JUMP:   begin v.pc_src = 2'b10; v.pc_en = 1'b1; end
            default:  ;
        endcase
        return v;
    endfunction

    // Monitor: every falling edge the DUT presents one output vector.
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL out_vec phase=%0d t=%0t got=%h want=%h", e.ph, $time, got, e.v);
            end
        end
    end

    // mode: 0 random, 1 force high, 2 force low
    function automatic logic pick(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic step(input int ph, input int rmode, input int zmode, output logic rdy);
        logic z;
        rdy = pick(rmode);
        z   = (zmode == 0) ? 1'($urandom_range(0, 1)) : pick(zmode);
        memReady_i = rdy;
        zero_i     = z;
        q.push_back('{v: expect_out(ph, rdy, z, opcode_i, funct_i), ph: ph});
        @(posedge clk_i);
        #1;
    endtask

    task automatic mem_wait(input int ph, input int rmode);
        int   n;
        logic r;
        n = 0;
        do begin
            step(ph, (n >= 6) ? 1 : rmode, 0, r);
            n++;
        end while (!r);
    endtask

    task automatic reset_cycles(input int n);
        rst_n_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            memReady_i = 1'($urandom_range(0, 1));
            zero_i     = 1'($urandom_range(0, 1));
            q.push_back('{v: expect_out(P_RST, 1'b0, 1'b0, opcode_i, funct_i), ph: P_RST});
            @(posedge clk_i);
            #1;
        end
        rst_n_i = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int rmode, input int zmode);
        logic       r;
        logic [3:0] fa;
        opcode_i = op;
        funct_i  = fn;
        mem_wait(P_FETCH, rmode);
        step(P_DECODE, 0, 0, r);
        case (op)
            6'b100011: begin
                step(P_MEMADR, 0, 0, r);
                mem_wait(P_MEMRD, rmode);
                step(P_MEMWB, 0, 0, r);
            end
            6'b101011: begin
                step(P_MEMADR, 0, 0, r);
                mem_wait(P_MEMWR, rmode);
            end
            6'b000000: begin
                fa = funct_alu(fn);
                step(P_EXEC, 0, 0, r);
                if (fa[3]) step(P_ALUWB, 0, 0, r);
            end
            6'b000100: step(P_BRANCH, 0, zmode, r);
            6'b001000: begin
                step(P_ADDIEX, 0, 0, r);
                step(P_ADDIWB, 0, 0, r);
            end
            6'b000010: step(P_JUMP, 0, 0, r);
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] legal_fn [5];
        legal_fn[0] = 6'b100000;
        legal_fn[1] = 6'b100010;
        legal_fn[2] = 6'b100100;
        legal_fn[3] = 6'b100101;
        legal_fn[4] = 6'b101010;

        @(posedge clk_i);
        #1;
        reset_cycles(5);

        // Directed: lw, slt, beq taken / not taken, addi, j.
        run_instr(6'b100011, 6'd0, 1, 0);
        run_instr(6'b000000, 6'b101010, 1, 0);
        run_instr(6'b000100, 6'd0, 1, 1);
        run_instr(6'b000100, 6'd0, 1, 2);
        run_instr(6'b001000, 6'd0, 1, 0);
        run_instr(6'b000010, 6'd0, 1, 0);

        // sw with memory not ready for 3 cycles: memWrite held 4 cycles.
        opcode_i = 6'b101011;
        funct_i  = 6'd0;
        mem_wait(P_FETCH, 1);
        step(P_DECODE, 0, 0, r);
        step(P_MEMADR, 0, 0, r);
        for (int i = 0; i < 3; i++) step(P_MEMWR, 2, 0, r);
        step(P_MEMWR, 1, 0, r);

        // Illegal opcode and illegal funct.
        run_instr(6'b111111, 6'd0, 1, 0);
        run_instr(6'b000000, 6'b111111, 1, 0);

        // Reset dropped while a store is waiting in its write phase.
        opcode_i = 6'b101011;
        mem_wait(P_FETCH, 1);
        step(P_DECODE, 0, 0, r);
        step(P_MEMADR, 0, 0, r);
        step(P_MEMWR, 2, 0, r);
        step(P_MEMWR, 2, 0, r);
        reset_cycles(2);
        run_instr(6'b100011, 6'd0, 0, 0);

        // Randomized instruction stream with random memory wait states.
        for (int k = 0; k < 120; k++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2, 6: begin
                    op = 6'b000000;
                    if ($urandom_range(0, 4) != 0) fn = legal_fn[$urandom_range(0, 4)];
                end
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op_known(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(op, fn, 0, 0);
        end

        repeat (2) @(negedge clk_i);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
